// File: rtl/mse_window_meter_if.sv
`default_nettype none
// ============================================================================
// Module      : mse_window_meter_if
// Description : Sample/control bundle between a FIR-pair source and the
//               mse_window_meter scoring block.
//               master : source/controller (drives start, samples)
//               slave  : the meter (drives status and results)
//   start       master->slave  one-cycle request to open a new window
//   in_valid    master->slave  y_approx/y_exact pair valid this cycle
//   y_approx    master->slave  signed approximate FIR output (DATA_W)
//   y_exact     master->slave  signed exact FIR output (DATA_W)
//   busy        slave->master  window in progress (RUN or DRAIN)
//   done        slave->master  one-cycle pulse when results update
//   sse         slave->master  sum of squared errors (ACC_W)
//   mse         slave->master  sse >> LOG2_N (2*DATA_W)
//   max_abs_err slave->master  largest |diff| in window (DATA_W+1),
//                              present only when MSE_PEAK_EN is defined
// Optional    : MSE_PEAK_EN
// Revision    : 1.0 - initial release
// ============================================================================
interface mse_window_meter_if #(
    parameter int DATA_W = 16,
    parameter int LOG2_N = 10
);
    localparam int ACC_W = 2*DATA_W + LOG2_N;

    logic                     start;
    logic                     in_valid;
    logic signed [DATA_W-1:0] y_approx;
    logic signed [DATA_W-1:0] y_exact;
    logic                     busy;
    logic                     done;
    logic [ACC_W-1:0]         sse;
    logic [2*DATA_W-1:0]      mse;
`ifdef MSE_PEAK_EN
    logic [DATA_W:0]          max_abs_err;
`endif

    modport master (
        output start,
        output in_valid,
        output y_approx,
        output y_exact,
        input  busy,
        input  done,
        input  sse,
`ifdef MSE_PEAK_EN
        input  max_abs_err,
`endif
        input  mse
    );

    modport slave (
        input  start,
        input  in_valid,
        input  y_approx,
        input  y_exact,
        output busy,
        output done,
        output sse,
`ifdef MSE_PEAK_EN
        output max_abs_err,
`endif
        output mse
    );
endinterface
`default_nettype wire

// File: rtl/mse_window_meter.sv
`default_nettype none
// ============================================================================
// Module      : mse_window_meter
// Description : Scores an approximate-adder FIR against its exact twin.
//               Accumulates (y_approx - y_exact)^2 over a window of
//               N = 2^LOG2_N valid samples and reports SSE and MSE
//               (SSE >> LOG2_N, truncating).
// Ports       : clk   rising-edge clock
//               rstN  synchronous active-low reset
//               bus   mse_window_meter_if.slave (start, in_valid,
//                     y_approx, y_exact, busy, done, sse, mse
//                     [, max_abs_err])
// Parameters  : DATA_W - sample width, LOG2_N - log2 of window length.
//               ACC_W = 2*DATA_W+LOG2_N is derived internally. The
//               interface instance must use the same DATA_W/LOG2_N.
// Optional    : MSE_PEAK_EN - adds max_abs_err, the largest |diff| seen
//               in the window, latched together with sse/mse.
// Datapath    : S1 diff -> S2 square -> S3 accumulate, each with a valid.
//               Last sample accepted at edge E gives done in the cycle
//               after edge E+4.
// Revision    : 1.0 - initial release
// ============================================================================
module mse_window_meter #(
    parameter int DATA_W = 16,
    parameter int LOG2_N = 10
) (
    input  logic                  clk,
    input  logic                  rstN,
    mse_window_meter_if.slave     bus
);

    localparam int ACC_W = 2*DATA_W + LOG2_N;

    // Counter value at which the accepted sample is the last of the window.
    localparam logic [LOG2_N-1:0] c_CNT_LAST = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // FSM decode
    logic w_busy;
    logic w_done;
    logic w_clear;   // start honoured: wipe accumulator/counter
    logic w_accept;  // pair enters S1 this cycle
    logic w_latch;   // pipeline empty in DRAIN: publish results

    // Sample counter and pipeline
    logic [LOG2_N-1:0]   r_cnt;
    logic                r_s1_vld;
    logic [DATA_W:0]     r_s1_diff;
    logic                r_s2_vld;
    logic [2*DATA_W-1:0] r_s2_sq;
    logic                r_s3_vld;
    logic [ACC_W-1:0]    r_acc;

    // Published results
    logic [ACC_W-1:0]    r_sse;
    logic [2*DATA_W-1:0] r_mse;

    // Combinational datapath
    logic [DATA_W:0]     w_diff;
    logic [DATA_W:0]     w_abs;
    logic [2*DATA_W-1:0] w_abs_ext;
    logic [2*DATA_W-1:0] w_sq;
    logic [ACC_W-1:0]    w_sq_ext;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_clear     = 1'b0;
        w_accept    = 1'b0;
        w_latch     = 1'b0;
        case (r_state)
            S_IDLE: begin
                // in_valid is deliberately ignored here, even alongside start.
                if (bus.start) begin
                    w_clear     = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (bus.in_valid) begin
                    w_accept = 1'b1;
                    if (r_cnt == c_CNT_LAST) begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                w_busy = 1'b1;
                // S3 valid covers the cycle in which the final sum settles
                // in r_acc, so results are taken one cycle after it.
                if (!r_s1_vld && !r_s2_vld && !r_s3_vld) begin
                    w_latch     = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Arithmetic
    // ------------------------------------------------------------------
    // One extra bit makes the difference exact for any pair of inputs.
    assign w_diff = {bus.y_approx[DATA_W-1], bus.y_approx}
                  - {bus.y_exact[DATA_W-1],  bus.y_exact};

    // |diff| <= 2^DATA_W - 1, so squaring the magnitude never overflows
    // 2*DATA_W bits and avoids a signed multiplier.
    assign w_abs     = r_s1_diff[DATA_W] ? ((~r_s1_diff) + (DATA_W+1)'(1))
                                         : r_s1_diff;
    assign w_abs_ext = {{(DATA_W-1){1'b0}}, w_abs};
    assign w_sq      = w_abs_ext * w_abs_ext;
    assign w_sq_ext  = {{LOG2_N{1'b0}}, r_s2_sq};

    // ------------------------------------------------------------------
    // Pipeline, counter, accumulator, result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_cnt     <= '0;
            r_s1_vld  <= 1'b0;
            r_s1_diff <= '0;
            r_s2_vld  <= 1'b0;
            r_s2_sq   <= '0;
            r_s3_vld  <= 1'b0;
            r_acc     <= '0;
            r_sse     <= '0;
            r_mse     <= '0;
        end else begin
            // S1: capture the difference of an accepted pair
            r_s1_vld <= w_accept;
            if (w_accept) begin
                r_s1_diff <= w_diff;
            end

            // S2: square
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_s2_sq <= w_sq;
            end

            // S3: accumulate; the valid marks the accumulate cycle
            r_s3_vld <= r_s2_vld;

            if (w_clear) begin
                r_cnt <= '0;
                r_acc <= '0;
            end else begin
                if (w_accept) begin
                    r_cnt <= r_cnt + LOG2_N'(1);
                end
                if (r_s2_vld) begin
                    r_acc <= r_acc + w_sq_ext;
                end
            end

            // Results hold until the next window completes; start does
            // not touch them.
            if (w_latch) begin
                r_sse <= r_acc;
                r_mse <= r_acc[ACC_W-1:LOG2_N];
            end
        end
    end

`ifdef MSE_PEAK_EN
    // ------------------------------------------------------------------
    // Peak |diff| tracker, updated alongside the S2 square
    // ------------------------------------------------------------------
    logic [DATA_W:0] r_peak;
    logic [DATA_W:0] r_max_abs;

    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_peak    <= '0;
            r_max_abs <= '0;
        end else begin
            if (w_clear) begin
                r_peak <= '0;
            end else if (r_s1_vld && (w_abs > r_peak)) begin
                r_peak <= w_abs;
            end
            if (w_latch) begin
                r_max_abs <= r_peak;
            end
        end
    end

    assign bus.max_abs_err = r_max_abs;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.busy = w_busy;
    assign bus.done = w_done;
    assign bus.sse  = r_sse;
    assign bus.mse  = r_mse;

endmodule
`default_nettype wire
